// File: rtl/multiport_ram_pkg.sv
// Shared defaults and types for the replicated-bank multi-port RAM.
// Default geometry matches the CPU datapath register memory.
package multiport_ram_pkg;

   localparam int MP_W        = 32;
   localparam int MP_DEPTH    = 64;
   localparam int MP_NRD      = 6;
   localparam int MP_INIT_VAL = 1;
   localparam int MP_BYPASS   = 1;

   typedef enum logic {
      S_INIT  = 1'b0,
      S_READY = 1'b1
   } state_t;

endpackage

// File: rtl/mp_bank.sv
// One storage bank: two write ports (port a wins on collision) and two
// registered read ports with optional same-edge write-to-read bypass.
module mp_bank #(
   parameter int W      = 32,
   parameter int DEPTH  = 64,
   parameter int AW     = $clog2(DEPTH),
   parameter int BYPASS = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            we_a,
   input  logic [AW-1:0]   addr_a,
   input  logic [W-1:0]    data_a,
   input  logic            we_b,
   input  logic [AW-1:0]   addr_b,
   input  logic [W-1:0]    data_b,
   input  logic [1:0]      rd_en,
   input  logic [1:0]      rd_ok,
   input  logic [2*AW-1:0] rd_addr,
   output logic [2*W-1:0]  rd_data
);

   logic [W-1:0] mem [DEPTH];
   logic [W-1:0] rd_next [2];
   logic [W-1:0] rd_q    [2];

   // NOTE: the storage array carries no reset; clearing it would turn the RAM
   // into a flop bank. The init sweep in the parent gives it defined contents.
   always_ff @(posedge clk) begin
      if (we_b) mem[addr_b] <= data_b;
      if (we_a) mem[addr_a] <= data_a;
   end

   // NOTE: every variable written here gets a default first so no latch forms.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rd_next[p] = '0;
         if (rd_ok[p]) begin
            if (BYPASS != 0 && we_a && addr_a == rd_addr[p*AW +: AW])
               rd_next[p] = data_a;
            else if (BYPASS != 0 && we_b && addr_b == rd_addr[p*AW +: AW])
               rd_next[p] = data_b;
            else
               rd_next[p] = mem[rd_addr[p*AW +: AW]];
         end
      end
   end

   // NOTE: registers use non-blocking assignments so all flops sample together.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_q[0] <= '0;
         rd_q[1] <= '0;
      end else begin
         for (int p = 0; p < 2; p++)
            if (rd_en[p]) rd_q[p] <= rd_next[p];
      end
   end

   assign rd_data = {rd_q[1], rd_q[0]};

endmodule

// File: rtl/multiport_ram.sv
// Two-write, NRD-read memory built from NRD/2 coherent replicas of mp_bank,
// with a reset-driven init sweep, range checks and write-conflict flagging.
module multiport_ram
   import multiport_ram_pkg::*;
#(
   parameter int             W        = MP_W,
   parameter int             DEPTH    = MP_DEPTH,
   parameter int             AW       = $clog2(DEPTH),
   parameter int             NRD      = MP_NRD,
   parameter logic [W-1:0]   INIT_VAL = W'(MP_INIT_VAL),
   parameter int             BYPASS   = MP_BYPASS
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we_a,
   input  logic              we_b,
   input  logic [AW-1:0]     addr_a,
   input  logic [AW-1:0]     addr_b,
   input  logic [W-1:0]      data_a,
   input  logic [W-1:0]      data_b,
   input  logic [NRD-1:0]    rd_en,
   input  logic [NRD*AW-1:0] rd_addr,
   output logic [NRD*W-1:0]  rd_data,
   output logic [NRD-1:0]    rd_valid,
   output logic              init_done,
   output logic              wr_conflict
);

   localparam int            NBANK     = NRD / 2;
   localparam logic [AW:0]   DEPTH_X   = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   state_t         state_q, state_d;
   logic [AW-1:0]  cnt_q, cnt_d;
   logic           ready;
   logic           a_ok, b_ok;
   logic           bank_we_a, bank_we_b;
   logic [AW-1:0]  bank_addr_a;
   logic [W-1:0]   bank_data_a;
   logic [NRD-1:0] bank_rd_en;
   logic [NRD-1:0] rd_ok;
   logic [NRD-1:0] rd_valid_q;
   logic           wr_conflict_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_INIT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) begin
               state_d = S_READY;
               cnt_d   = '0;
            end
         end
         default: ;
      endcase
   end

   assign ready = (state_q == S_READY);
   assign a_ok  = {1'b0, addr_a} < DEPTH_X;
   assign b_ok  = {1'b0, addr_b} < DEPTH_X;

   // During the sweep port a is borrowed for the init write; user writes wait.
   assign bank_we_a   = rst_n && (ready ? (we_a && a_ok) : 1'b1);
   assign bank_addr_a = ready ? addr_a : cnt_q;
   assign bank_data_a = ready ? data_a : INIT_VAL;
   assign bank_we_b   = rst_n && ready && we_b && b_ok;
   assign bank_rd_en  = ready ? rd_en : '0;

   for (genvar i = 0; i < NRD; i++) begin : g_rd_range
      assign rd_ok[i] = {1'b0, rd_addr[i*AW +: AW]} < DEPTH_X;
   end

   for (genvar g = 0; g < NBANK; g++) begin : g_bank
      mp_bank #(
         .W      (W),
         .DEPTH  (DEPTH),
         .AW     (AW),
         .BYPASS (BYPASS)
      ) u_bank (
         .clk     (clk),
         .rst_n   (rst_n),
         .we_a    (bank_we_a),
         .addr_a  (bank_addr_a),
         .data_a  (bank_data_a),
         .we_b    (bank_we_b),
         .addr_b  (addr_b),
         .data_b  (data_b),
         .rd_en   (bank_rd_en[2*g +: 2]),
         .rd_ok   (rd_ok[2*g +: 2]),
         .rd_addr (rd_addr[2*g*AW +: 2*AW]),
         .rd_data (rd_data[2*g*W +: 2*W])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_valid_q    <= '0;
         wr_conflict_q <= 1'b0;
      end else begin
         rd_valid_q    <= bank_rd_en;
         wr_conflict_q <= ready && we_a && we_b && a_ok && b_ok && (addr_a == addr_b);
      end
   end

   assign rd_valid    = rd_valid_q;
   assign wr_conflict = wr_conflict_q;
   assign init_done   = ready;

endmodule
